// File: rtl/ball_pkg.sv
// Shared geometry, FSM state type and small helpers for the pong ball engine.
// Coordinates are ball/paddle centres; limits below are where the ball edge meets a wall.
package ball_pkg;

   localparam int FIELD_W    = 640;
   localparam int FIELD_H    = 480;
   localparam int BALL_HW    = 10;
   localparam int BALL_HH    = 15;
   localparam int PAD_HW     = 25;
   localparam int PAD_HH     = 33;
   localparam int GOAL_Y_MIN = 200;
   localparam int GOAL_Y_MAX = 280;
   localparam int CENTRE_X   = 320;
   localparam int CENTRE_Y   = 240;

   localparam int X_MIN  = BALL_HW;
   localparam int X_MAX  = FIELD_W - BALL_HW - 1;
   localparam int Y_MIN  = BALL_HH;
   localparam int Y_MAX  = FIELD_H - BALL_HH - 1;
   localparam int HIT_DX = BALL_HW + PAD_HW;
   localparam int HIT_DY = BALL_HH + PAD_HH;

   // Wide enough that a step off either edge of the field stays representable
   localparam int CW = 12;
   typedef logic signed [CW-1:0] coord_t;

   typedef enum logic [1:0] {SERVE, MOVE, SCORED, OVER} state_t;

   function automatic coord_t absDiff(input coord_t a, input coord_t b);
      coord_t d;
      d = a - b;
      return d[CW-1] ? -d : d;
   endfunction

   function automatic logic inMouth(input logic [8:0] y);
      return (y >= 9'(GOAL_Y_MIN)) && (y <= 9'(GOAL_Y_MAX));
   endfunction

   function automatic logic [3:0] satInc(input logic [3:0] s);
      return (s >= 4'd9) ? 4'd9 : s + 4'd1;
   endfunction

endpackage

// File: rtl/ball_collide.sv
// Overlap test between the ball's proposed next position and one paddle.
module ball_collide
   import ball_pkg::*;
(
   input  coord_t     nx,
   input  coord_t     ny,
   input  logic [9:0] padX,
   input  logic [8:0] padY,
   output logic       hit
);

   coord_t px;
   coord_t py;

   assign px  = coord_t'({2'b00, padX});
   assign py  = coord_t'({3'b000, padY});
   assign hit = (absDiff(nx, px) < coord_t'(HIT_DX)) &&
                (absDiff(ny, py) < coord_t'(HIT_DY));

endmodule

// File: rtl/ball_physics.sv
// Ball motion, paddle/wall bounces, goals and scoring for a two-player pong field.
// All state advances on frame_tick; restart and reset return the game to a fresh serve.
module ball_physics
   import ball_pkg::*;
#(
   parameter int VX           = 2,
   parameter int VY           = 1,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 5
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       restart,
   input  logic [9:0] p1_x,
   input  logic [8:0] p1_y,
   input  logic [9:0] p2_x,
   input  logic [8:0] p2_y,
   output logic [9:0] ball_x,
   output logic [8:0] ball_y,
   output logic       pos_valid,
   output logic [3:0] score_p1,
   output logic [3:0] score_p2,
   output logic [1:0] winner
);

   localparam int               CNT_W      = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam coord_t           VX_S       = coord_t'(VX);
   localparam coord_t           VY_S       = coord_t'(VY);
   localparam coord_t           X_MIN_S    = coord_t'(X_MIN);
   localparam coord_t           X_MAX_S    = coord_t'(X_MAX);
   localparam coord_t           Y_MIN_S    = coord_t'(Y_MIN);
   localparam coord_t           Y_MAX_S    = coord_t'(Y_MAX);
   localparam logic [9:0]       CX         = 10'(CENTRE_X);
   localparam logic [8:0]       CY         = 9'(CENTRE_Y);

   state_t           state, stateNext;
   logic [9:0]       ballX, ballXNext;
   logic [8:0]       ballY, ballYNext;
   logic             vxNeg, vxNegNext;
   logic             vyNeg, vyNegNext;
   logic             serveLeft, serveLeftNext;
   logic [CNT_W-1:0] serveCnt, serveCntNext;
   logic [3:0]       scoreP1, scoreP1Next;
   logic [3:0]       scoreP2, scoreP2Next;
   logic [1:0]       winnerReg, winnerNext;
   logic             posValid, posValidNext;
   coord_t           nx, ny;
   logic             hit1, hit2;
   logic [9:0]       hitPadX;
   logic [3:0]       scorerScore;

   assign nx = coord_t'({2'b00, ballX}) + (vxNeg ? -VX_S : VX_S);
   assign ny = coord_t'({3'b000, ballY}) + (vyNeg ? -VY_S : VY_S);

   ball_collide u_collideP1 (.nx(nx), .ny(ny), .padX(p1_x), .padY(p1_y), .hit(hit1));
   ball_collide u_collideP2 (.nx(nx), .ny(ny), .padX(p2_x), .padY(p2_y), .hit(hit2));

   // serveLeft doubles as "P2 scored last", so it also identifies the scorer in SCORED
   assign hitPadX     = hit1 ? p1_x : p2_x;
   assign scorerScore = serveLeft ? scoreP2 : scoreP1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SERVE;
         ballX     <= CX;
         ballY     <= CY;
         vxNeg     <= 1'b0;
         vyNeg     <= 1'b0;
         serveLeft <= 1'b0;
         serveCnt  <= '0;
         scoreP1   <= 4'd0;
         scoreP2   <= 4'd0;
         winnerReg <= 2'd0;
         posValid  <= 1'b0;
      end else begin
         state     <= stateNext;
         ballX     <= ballXNext;
         ballY     <= ballYNext;
         vxNeg     <= vxNegNext;
         vyNeg     <= vyNegNext;
         serveLeft <= serveLeftNext;
         serveCnt  <= serveCntNext;
         scoreP1   <= scoreP1Next;
         scoreP2   <= scoreP2Next;
         winnerReg <= winnerNext;
         posValid  <= posValidNext;
      end
   end

   always_comb begin
      stateNext     = state;
      ballXNext     = ballX;
      ballYNext     = ballY;
      vxNegNext     = vxNeg;
      vyNegNext     = vyNeg;
      serveLeftNext = serveLeft;
      serveCntNext  = serveCnt;
      scoreP1Next   = scoreP1;
      scoreP2Next   = scoreP2;
      winnerNext    = winnerReg;
      posValidNext  = 1'b0;

      if (restart) begin
         stateNext     = SERVE;
         ballXNext     = CX;
         ballYNext     = CY;
         vxNegNext     = 1'b0;
         vyNegNext     = 1'b0;
         serveLeftNext = 1'b0;
         serveCntNext  = '0;
         scoreP1Next   = 4'd0;
         scoreP2Next   = 4'd0;
         winnerNext    = 2'd0;
      end else if (frame_tick) begin
         posValidNext = (state != OVER);
         unique case (state)
            SERVE: begin
               if (serveCnt == SERVE_LAST) begin
                  stateNext    = MOVE;
                  vxNegNext    = serveLeft;
                  vyNegNext    = 1'b0;
                  serveCntNext = '0;
               end else begin
                  serveCntNext = serveCnt + 1'b1;
               end
            end
            MOVE: begin
               if (ny < Y_MIN_S) begin
                  ballYNext = 9'(Y_MIN);
                  vyNegNext = 1'b0;
               end else if (ny > Y_MAX_S) begin
                  ballYNext = 9'(Y_MAX);
                  vyNegNext = 1'b1;
               end else begin
                  ballYNext = ny[8:0];
               end

               // Goal beats paddle beats side wall; on a goal the ball x stays where it was
               if ((nx < X_MIN_S) && inMouth(ballY)) begin
                  scoreP2Next   = satInc(scoreP2);
                  serveLeftNext = 1'b1;
                  stateNext     = SCORED;
               end else if ((nx > X_MAX_S) && inMouth(ballY)) begin
                  scoreP1Next   = satInc(scoreP1);
                  serveLeftNext = 1'b0;
                  stateNext     = SCORED;
               end else if (hit1 || hit2) begin
                  vxNegNext = (ballX < hitPadX);
               end else if (nx < X_MIN_S) begin
                  ballXNext = 10'(X_MIN);
                  vxNegNext = 1'b0;
               end else if (nx > X_MAX_S) begin
                  ballXNext = 10'(X_MAX);
                  vxNegNext = 1'b1;
               end else begin
                  ballXNext = nx[9:0];
               end
            end
            SCORED: begin
               ballXNext    = CX;
               ballYNext    = CY;
               serveCntNext = '0;
               if (scorerScore >= 4'(WIN_SCORE)) begin
                  stateNext  = OVER;
                  winnerNext = serveLeft ? 2'd2 : 2'd1;
               end else begin
                  stateNext = SERVE;
               end
            end
            OVER: begin
               stateNext = OVER;
            end
            default: begin
               stateNext = SERVE;
            end
         endcase
      end
   end

   assign ball_x    = ballX;
   assign ball_y    = ballY;
   assign pos_valid = posValid;
   assign score_p1  = scoreP1;
   assign score_p2  = scoreP2;
   assign winner    = winnerReg;

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics: trajectories are hand-traced from centre serves
// with paddles parked off-field or placed to force a specific bounce.
module tb_ball_physics;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic       restart;
   logic [9:0] p1_x, p2_x;
   logic [8:0] p1_y, p2_y;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic       pos_valid;
   logic [3:0] score_p1, score_p2;
   logic [1:0] winner;

   int total = 0;
   int bad   = 0;

   ball_physics #(.VX(2), .VY(1), .SERVE_FRAMES(60), .WIN_SCORE(5)) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .restart(restart),
      .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
      .ball_x(ball_x), .ball_y(ball_y), .pos_valid(pos_valid),
      .score_p1(score_p1), .score_p2(score_p2), .winner(winner)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         @(posedge clk);
         #1;
         frame_tick = 1'b0;
      end
   endtask

   task automatic pulseRestart();
      restart = 1'b1;
      @(posedge clk);
      #1;
      restart = 1'b0;
   endtask

   task automatic parkPaddles();
      p1_x = 10'd1000; p1_y = 9'd0;
      p2_x = 10'd1000; p2_y = 9'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      total++;
      if (ball_x !== 10'd320 || ball_y !== 9'd240) begin
         bad++;
         $display("[TB] FAIL reset_pos got=(%0d,%0d) want=(320,240)", ball_x, ball_y);
      end
      total++;
      if (score_p1 !== 4'd0 || score_p2 !== 4'd0 || winner !== 2'd0 || pos_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_regs got s1=%0d s2=%0d w=%0d pv=%0b want 0 0 0 0",
                  score_p1, score_p2, winner, pos_valid);
      end
   endtask

   task automatic test_serve();
      for (int i = 1; i <= 60; i++) begin
         ticks(1);
         total++;
         if (ball_x !== 10'd320 || ball_y !== 9'd240 || pos_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL serve_hold tick=%0d got=(%0d,%0d) pv=%0b want=(320,240) pv=1",
                     i, ball_x, ball_y, pos_valid);
         end
      end
      ticks(1);
      total++;
      if (ball_x !== 10'd322 || ball_y !== 9'd241 || pos_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL serve_first_move got=(%0d,%0d) pv=%0b want=(322,241) pv=1",
                  ball_x, ball_y, pos_valid);
      end
      @(posedge clk);
      #1;
      total++;
      if (pos_valid !== 1'b0 || ball_x !== 10'd322 || ball_y !== 9'd241) begin
         bad++;
         $display("[TB] FAIL pos_valid_pulse got pv=%0b pos=(%0d,%0d) want pv=0 pos=(322,241)",
                  pos_valid, ball_x, ball_y);
      end
   endtask

   // Continues the serve above: right wall, bottom wall, P1 paddle at (100,286), right wall, top wall
   task automatic test_walls();
      int rows [16][3];
      int k;
      rows = '{'{154, 628, 394}, '{155, 629, 395}, '{156, 627, 396},
               '{224, 491, 464}, '{225, 489, 464}, '{226, 487, 463},
               '{402, 135, 287}, '{403, 135, 286}, '{404, 137, 285},
               '{650, 629,  39}, '{651, 629,  38}, '{652, 627,  37},
               '{673, 585,  16}, '{674, 583,  15}, '{675, 581,  15},
               '{676, 579,  16}};
      k = 1;
      for (int r = 0; r < 16; r++) begin
         ticks(rows[r][0] - k);
         k = rows[r][0];
         total++;
         if (ball_x !== 10'(rows[r][1]) || ball_y !== 9'(rows[r][2])) begin
            bad++;
            $display("[TB] FAIL walls k=%0d got=(%0d,%0d) want=(%0d,%0d)",
                     k, ball_x, ball_y, rows[r][1], rows[r][2]);
         end
      end
   endtask

   task automatic test_paddle();
      int rows [4][3];
      parkPaddles();
      p2_x = 10'd560;
      p2_y = 9'd345;
      pulseRestart();
      total++;
      if (ball_x !== 10'd320 || ball_y !== 9'd240 || score_p1 !== 4'd0 || score_p2 !== 4'd0) begin
         bad++;
         $display("[TB] FAIL restart_midgame got=(%0d,%0d) s1=%0d s2=%0d want=(320,240) 0 0",
                  ball_x, ball_y, score_p1, score_p2);
      end
      ticks(60);
      rows = '{'{101, 522, 341}, '{1, 524, 342}, '{1, 524, 343}, '{1, 522, 344}};
      for (int r = 0; r < 4; r++) begin
         ticks(rows[r][0]);
         total++;
         if (ball_x !== 10'(rows[r][1]) || ball_y !== 9'(rows[r][2])) begin
            bad++;
            $display("[TB] FAIL paddle step=%0d got=(%0d,%0d) want=(%0d,%0d)",
                     r, ball_x, ball_y, rows[r][1], rows[r][2]);
         end
      end
   endtask

   task automatic test_goal();
      int rows [4][3];
      parkPaddles();
      pulseRestart();
      ticks(60 + 464);
      total++;
      if (ball_x !== 10'd11 || ball_y !== 9'd225) begin
         bad++;
         $display("[TB] FAIL goal_approach got=(%0d,%0d) want=(11,225)", ball_x, ball_y);
      end
      ticks(1);
      total++;
      if (score_p2 !== 4'd1 || score_p1 !== 4'd0 || pos_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL goal_p2 got s1=%0d s2=%0d pv=%0b want s1=0 s2=1 pv=1",
                  score_p1, score_p2, pos_valid);
      end
      ticks(1);
      total++;
      if (ball_x !== 10'd320 || ball_y !== 9'd240 || score_p2 !== 4'd1 || winner !== 2'd0) begin
         bad++;
         $display("[TB] FAIL scored_to_serve got=(%0d,%0d) s2=%0d w=%0d want=(320,240) s2=1 w=0",
                  ball_x, ball_y, score_p2, winner);
      end
      ticks(60);
      total++;
      if (ball_x !== 10'd320 || ball_y !== 9'd240) begin
         bad++;
         $display("[TB] FAIL reserve_hold got=(%0d,%0d) want=(320,240)", ball_x, ball_y);
      end
      rows = '{'{1, 318, 241}, '{153, 12, 394}, '{1, 10, 395}, '{1, 10, 396}};
      for (int r = 0; r < 4; r++) begin
         ticks(rows[r][0]);
         total++;
         if (ball_x !== 10'(rows[r][1]) || ball_y !== 9'(rows[r][2])) begin
            bad++;
            $display("[TB] FAIL left_serve step=%0d got=(%0d,%0d) want=(%0d,%0d)",
                     r, ball_x, ball_y, rows[r][1], rows[r][2]);
         end
      end
      ticks(1);
      total++;
      if (ball_x !== 10'd12 || ball_y !== 9'd397) begin
         bad++;
         $display("[TB] FAIL left_reflect got=(%0d,%0d) want=(12,397)", ball_x, ball_y);
      end
   endtask

   task automatic test_reset_midgame();
      reset      = 1'b1;
      frame_tick = 1'b1;
      restart    = 1'b1;
      @(posedge clk);
      #1;
      reset      = 1'b0;
      frame_tick = 1'b0;
      restart    = 1'b0;
      total++;
      if (ball_x !== 10'd320 || ball_y !== 9'd240 || score_p2 !== 4'd0 || pos_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_midgame got=(%0d,%0d) s2=%0d pv=%0b want=(320,240) s2=0 pv=0",
                  ball_x, ball_y, score_p2, pos_valid);
      end
      ticks(60);
      total++;
      if (ball_x !== 10'd320 || ball_y !== 9'd240) begin
         bad++;
         $display("[TB] FAIL reset_serve_hold got=(%0d,%0d) want=(320,240)", ball_x, ball_y);
      end
      ticks(1);
      total++;
      if (ball_x !== 10'd322 || ball_y !== 9'd241) begin
         bad++;
         $display("[TB] FAIL reset_serve_dir got=(%0d,%0d) want=(322,241)", ball_x, ball_y);
      end
   endtask

   // P1 paddle at (300,390) turns every serve into a P1 goal at (629,239) on move tick 451
   task automatic test_win();
      logic [1:0] wantWin;
      parkPaddles();
      p1_x = 10'd300;
      p1_y = 9'd390;
      pulseRestart();
      for (int pt = 1; pt <= 5; pt++) begin
         ticks(60);
         if (pt == 1) begin
            ticks(303);
            total++;
            if (ball_x !== 10'd335 || ball_y !== 9'd386) begin
               bad++;
               $display("[TB] FAIL win_paddle got=(%0d,%0d) want=(335,386)", ball_x, ball_y);
            end
            ticks(147);
            total++;
            if (ball_x !== 10'd629 || ball_y !== 9'd239) begin
               bad++;
               $display("[TB] FAIL win_edge got=(%0d,%0d) want=(629,239)", ball_x, ball_y);
            end
            ticks(1);
         end else begin
            ticks(451);
         end
         total++;
         if (score_p1 !== 4'(pt) || score_p2 !== 4'd0) begin
            bad++;
            $display("[TB] FAIL p1_goal pt=%0d got s1=%0d s2=%0d want s1=%0d s2=0",
                     pt, score_p1, score_p2, pt);
         end
         ticks(1);
         wantWin = (pt == 5) ? 2'd1 : 2'd0;
         total++;
         if (winner !== wantWin || ball_x !== 10'd320 || ball_y !== 9'd240) begin
            bad++;
            $display("[TB] FAIL after_scored pt=%0d got w=%0d pos=(%0d,%0d) want w=%0d pos=(320,240)",
                     pt, winner, ball_x, ball_y, wantWin);
         end
      end
      for (int i = 0; i < 3; i++) begin
         ticks(1);
         total++;
         if (ball_x !== 10'd320 || ball_y !== 9'd240 || score_p1 !== 4'd5 ||
             score_p2 !== 4'd0 || winner !== 2'd1 || pos_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL over_frozen i=%0d got=(%0d,%0d) s1=%0d s2=%0d w=%0d pv=%0b want=(320,240) 5 0 1 0",
                     i, ball_x, ball_y, score_p1, score_p2, winner, pos_valid);
         end
      end
      restart    = 1'b1;
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      restart    = 1'b0;
      frame_tick = 1'b0;
      total++;
      if (score_p1 !== 4'd0 || score_p2 !== 4'd0 || winner !== 2'd0 ||
          ball_x !== 10'd320 || ball_y !== 9'd240) begin
         bad++;
         $display("[TB] FAIL restart_over got s1=%0d s2=%0d w=%0d pos=(%0d,%0d) want 0 0 0 (320,240)",
                  score_p1, score_p2, winner, ball_x, ball_y);
      end
      ticks(60);
      total++;
      if (ball_x !== 10'd320 || ball_y !== 9'd240) begin
         bad++;
         $display("[TB] FAIL restart_serve_hold got=(%0d,%0d) want=(320,240)", ball_x, ball_y);
      end
      ticks(1);
      total++;
      if (ball_x !== 10'd322 || ball_y !== 9'd241) begin
         bad++;
         $display("[TB] FAIL restart_serve_move got=(%0d,%0d) want=(322,241)", ball_x, ball_y);
      end
   endtask

   initial begin
      reset      = 1'b1;
      frame_tick = 1'b0;
      restart    = 1'b0;
      parkPaddles();
      p1_x = 10'd100;
      p1_y = 9'd286;
      test_reset();
      test_serve();
      test_walls();
      test_paddle();
      test_goal();
      test_reset_midgame();
      test_win();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
